// File: rtl/param_stack.sv
// Parametrised LIFO return-address stack for the uPC sequencer.
// All state changes on the falling edge of nclk; data_out/empty/full are combinational.
module param_stack #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter bit          WRAP_ON_FULL = 1'b0
) (
    input  logic                       nclk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    top_idx_q, top_idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    idx_inc, idx_dec;
    logic             ovf_set, unf_set;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FullCnt);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign data_out  = empty ? '0 : mem_q[top_idx_q];

    // Explicit modulo-DEPTH stepping so non-power-of-two depths wrap correctly.
    assign idx_inc = (top_idx_q == LastIdx) ? '0 : top_idx_q + IW'(1);
    assign idx_dec = (top_idx_q == '0) ? LastIdx : top_idx_q - IW'(1);

    always_comb begin
        top_idx_d = top_idx_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = top_idx_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        unique case ({push, pop})
            2'b11: begin
                if (empty) begin
                    // Push+pop on an empty stack degrades to a plain push.
                    top_idx_d = idx_inc;
                    wr_idx    = idx_inc;
                    wr_en     = 1'b1;
                    count_d   = count_q + CW'(1);
                end else begin
                    wr_en = 1'b1;
                end
            end
            2'b10: begin
                if (!full) begin
                    top_idx_d = idx_inc;
                    wr_idx    = idx_inc;
                    wr_en     = 1'b1;
                    count_d   = count_q + CW'(1);
                end else begin
                    ovf_set = 1'b1;
                    if (WRAP_ON_FULL) begin
                        top_idx_d = idx_inc;
                        wr_idx    = idx_inc;
                        wr_en     = 1'b1;
                    end
                end
            end
            2'b01: begin
                if (!empty) begin
                    top_idx_d = idx_dec;
                    count_d   = count_q - CW'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase

        // A new error on the same edge as clear_err takes precedence.
        overflow_d  = (overflow_q  & ~clear_err) | ovf_set;
        underflow_d = (underflow_q & ~clear_err) | unf_set;
    end

    always_ff @(negedge nclk) begin
        if (reset) begin
            top_idx_q   <= LastIdx;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            top_idx_q   <= top_idx_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (wr_en) begin
                mem_q[wr_idx] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: four configurations driven in lockstep, checked against a queue model.
module tb_param_stack;

    localparam int N = 4;

    logic       nclk;
    logic       reset, push, pop, clear_err;
    logic [7:0] data_in;

    // Instance 0: DEPTH 4 drop, 1: DEPTH 4 wrap, 2: DEPTH 5 wrap, 3: default DEPTH 16 drop.
    logic [7:0] d0, d1, d2, d3;
    logic [2:0] c0, c1, c2;
    logic [4:0] c3;
    logic       e0, e1, e2, e3, f0, f1, f2, f3;
    logic       o0, o1, o2, o3, u0, u1, u2, u3;

    logic [7:0] obs_data  [N];
    logic [7:0] obs_count [N];
    logic       obs_empty [N];
    logic       obs_full  [N];
    logic       obs_ov    [N];
    logic       obs_un    [N];

    int checks;
    int failures;

    int         mdepth [N] = '{4, 4, 5, 16};
    bit         mwrap  [N] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] mq     [N][$];
    bit         mov    [N];
    bit         mun    [N];

    param_stack #(.WIDTH(8), .DEPTH(4), .WRAP_ON_FULL(1'b0)) u_d4_drop (
        .nclk(nclk), .reset(reset), .push(push), .pop(pop), .clear_err(clear_err),
        .data_in(data_in), .data_out(d0), .count(c0), .empty(e0), .full(f0),
        .overflow(o0), .underflow(u0)
    );
    param_stack #(.WIDTH(8), .DEPTH(4), .WRAP_ON_FULL(1'b1)) u_d4_wrap (
        .nclk(nclk), .reset(reset), .push(push), .pop(pop), .clear_err(clear_err),
        .data_in(data_in), .data_out(d1), .count(c1), .empty(e1), .full(f1),
        .overflow(o1), .underflow(u1)
    );
    param_stack #(.WIDTH(8), .DEPTH(5), .WRAP_ON_FULL(1'b1)) u_d5_wrap (
        .nclk(nclk), .reset(reset), .push(push), .pop(pop), .clear_err(clear_err),
        .data_in(data_in), .data_out(d2), .count(c2), .empty(e2), .full(f2),
        .overflow(o2), .underflow(u2)
    );
    param_stack u_default (
        .nclk(nclk), .reset(reset), .push(push), .pop(pop), .clear_err(clear_err),
        .data_in(data_in), .data_out(d3), .count(c3), .empty(e3), .full(f3),
        .overflow(o3), .underflow(u3)
    );

    assign obs_data[0]  = d0;          assign obs_data[1]  = d1;
    assign obs_data[2]  = d2;          assign obs_data[3]  = d3;
    assign obs_count[0] = 8'(c0);      assign obs_count[1] = 8'(c1);
    assign obs_count[2] = 8'(c2);      assign obs_count[3] = 8'(c3);
    assign obs_empty[0] = e0;          assign obs_empty[1] = e1;
    assign obs_empty[2] = e2;          assign obs_empty[3] = e3;
    assign obs_full[0]  = f0;          assign obs_full[1]  = f1;
    assign obs_full[2]  = f2;          assign obs_full[3]  = f3;
    assign obs_ov[0]    = o0;          assign obs_ov[1]    = o1;
    assign obs_ov[2]    = o2;          assign obs_ov[3]    = o3;
    assign obs_un[0]    = u0;          assign obs_un[1]    = u1;
    assign obs_un[2]    = u2;          assign obs_un[3]    = u3;

    initial nclk = 1'b1;
    always #5 nclk = ~nclk;

    // Apply one edge of stimulus, advance the reference model, sample 1 time unit later.
    task automatic step(input bit rst, input bit p, input bit po, input bit ce,
                        input logic [7:0] d);
        reset = rst; push = p; pop = po; clear_err = ce; data_in = d;
        @(negedge nclk);
        for (int i = 0; i < N; i++) begin
            bit ov, un;
            ov = 1'b0;
            un = 1'b0;
            if (rst) begin
                mq[i].delete();
                mov[i] = 1'b0;
                mun[i] = 1'b0;
            end else begin
                if (p && po) begin
                    if (mq[i].size() == 0) mq[i].push_back(d);
                    else mq[i][mq[i].size() - 1] = d;
                end else if (p) begin
                    if (mq[i].size() < mdepth[i]) begin
                        mq[i].push_back(d);
                    end else begin
                        ov = 1'b1;
                        if (mwrap[i]) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(d);
                        end
                    end
                end else if (po) begin
                    if (mq[i].size() > 0) void'(mq[i].pop_back());
                    else un = 1'b1;
                end
                if (ce) begin
                    mov[i] = 1'b0;
                    mun[i] = 1'b0;
                end
                if (ov) mov[i] = 1'b1;
                if (un) mun[i] = 1'b1;
            end
        end
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_data[i] !== 8'h00 || obs_count[i] !== 8'd0 || obs_empty[i] !== 1'b1 ||
                obs_full[i] !== 1'b0 || obs_ov[i] !== 1'b0 || obs_un[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset inst%0d: data=%h count=%0d empty=%b full=%b ov=%b un=%b, want 00 0 1 0 0 0",
                         i, obs_data[i], obs_count[i], obs_empty[i], obs_full[i], obs_ov[i], obs_un[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] after_pop [3] = '{8'h22, 8'h11, 8'h00};
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, vals[k]);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_data[i] !== 8'h33 || obs_count[i] !== 8'd3) begin
                failures++;
                $display("FAIL push3 inst%0d: data=%h count=%0d, want 33 3", i, obs_data[i], obs_count[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_data[i] !== after_pop[k]) begin
                    failures++;
                    $display("FAIL pop%0d inst%0d: data=%h, want %h", k, i, obs_data[i], after_pop[k]);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_empty[i] !== 1'b1 || obs_un[i] !== 1'b0) begin
                failures++;
                $display("FAIL pop_empty inst%0d: empty=%b un=%b, want 1 0", i, obs_empty[i], obs_un[i]);
            end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_count[i] !== 8'd0 || obs_un[i] !== 1'b1 || obs_data[i] !== 8'h00) begin
                failures++;
                $display("FAIL underflow inst%0d: count=%0d un=%b data=%h, want 0 1 00",
                         i, obs_count[i], obs_un[i], obs_data[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_un[i] !== 1'b0) begin
                failures++;
                $display("FAIL clear_err inst%0d: un=%b, want 0", i, obs_un[i]);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_un[i] !== 1'b1) begin
                failures++;
                $display("FAIL err_beats_clear inst%0d: un=%b, want 1", i, obs_un[i]);
            end
        end
    endtask

    task automatic test_full_policy();
        logic [7:0] drop_seq [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
        logic [7:0] wrap_seq [4] = '{8'd5, 8'd4, 8'd3, 8'd0};
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 6; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(k));
        checks++;
        if (f0 !== 1'b1 || o0 !== 1'b1 || d0 !== 8'd4) begin
            failures++;
            $display("FAIL drop_full: full=%b ov=%b data=%h, want 1 1 04", f0, o0, d0);
        end
        checks++;
        if (c1 !== 3'd4 || o1 !== 1'b1 || d1 !== 8'd6) begin
            failures++;
            $display("FAIL wrap_full: count=%0d ov=%b data=%h, want 4 1 06", c1, o1, d1);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (d0 !== drop_seq[k]) begin
                failures++;
                $display("FAIL drop_pop%0d: data=%h, want %h", k, d0, drop_seq[k]);
            end
            checks++;
            if (d1 !== wrap_seq[k]) begin
                failures++;
                $display("FAIL wrap_pop%0d: data=%h, want %h", k, d1, wrap_seq[k]);
            end
        end
        checks++;
        if (e0 !== 1'b1 || e1 !== 1'b1) begin
            failures++;
            $display("FAIL full_drain_empty: empty drop=%b wrap=%b, want 1 1", e0, e1);
        end
    endtask

    task automatic test_replace_top();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hB5);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_data[i] !== 8'hB5 || obs_count[i] !== 8'd1 || obs_ov[i] !== 1'b0 ||
                obs_un[i] !== 1'b0) begin
                failures++;
                $display("FAIL replace inst%0d: data=%h count=%0d ov=%b un=%b, want B5 1 0 0",
                         i, obs_data[i], obs_count[i], obs_ov[i], obs_un[i]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h07);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_data[i] !== 8'h07 || obs_count[i] !== 8'd1 || obs_un[i] !== 1'b0) begin
                failures++;
                $display("FAIL pushpop_empty inst%0d: data=%h count=%0d un=%b, want 07 1 0",
                         i, obs_data[i], obs_count[i], obs_un[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_count[i] !== 8'd0 || obs_empty[i] !== 1'b1 || obs_ov[i] !== 1'b0 ||
                obs_un[i] !== 1'b0 || obs_data[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_mid inst%0d: count=%0d empty=%b ov=%b un=%b data=%h, want 0 1 0 0 00",
                         i, obs_count[i], obs_empty[i], obs_ov[i], obs_un[i], obs_data[i]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_data[i] !== 8'h44 || obs_count[i] !== 8'd1) begin
                failures++;
                $display("FAIL after_reset inst%0d: data=%h count=%0d, want 44 1",
                         i, obs_data[i], obs_count[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            bit rst, p, po, ce;
            rst = ($urandom_range(0, 99) < 2);
            p   = ($urandom_range(0, 99) < 55);
            po  = ($urandom_range(0, 99) < 45);
            ce  = ($urandom_range(0, 99) < 8);
            step(rst, p, po, ce, 8'($urandom));
            for (int i = 0; i < N; i++) begin
                logic [7:0] exp_data;
                int sz;
                sz = mq[i].size();
                exp_data = (sz == 0) ? 8'h00 : mq[i][sz - 1];
                checks++;
                if (obs_data[i] !== exp_data || obs_count[i] !== 8'(sz) ||
                    obs_empty[i] !== (sz == 0) || obs_full[i] !== (sz == mdepth[i]) ||
                    obs_ov[i] !== mov[i] || obs_un[i] !== mun[i]) begin
                    failures++;
                    $display("FAIL random step%0d inst%0d: data=%h count=%0d e=%b f=%b ov=%b un=%b, want %h %0d %b %b %b %b",
                             n, i, obs_data[i], obs_count[i], obs_empty[i], obs_full[i],
                             obs_ov[i], obs_un[i], exp_data, sz, (sz == 0), (sz == mdepth[i]),
                             mov[i], mun[i]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = 8'h00;
        @(posedge nclk);
        test_reset();
        test_push_pop();
        test_underflow();
        test_full_policy();
        test_replace_top();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
